// File: rtl/cmos_capture.sv
// rtl/cmos_capture.sv - camera byte stream to RGB444 frame-buffer writer
//
// Purpose: waits SKIP_FRAMES whole frames after capture_en, then packs
// byte pairs (R nibble, GB byte) into 12-bit pixels and issues one write
// per pixel to a frame buffer of H_ACTIVE*V_ACTIVE entries.
// Optional feature macro: CMOS_BLANK_FILL_EN - short frames are padded
// with zero pixels up to the last buffer address before frame_done.
//
// Ports:
//   clk              pixel clock, the only clock
//   rst              synchronous active-high reset
//   capture_en       enables frame capture (sampled in IDLE and at frame end)
//   cmos_vsync       camera vsync, active high; falling edge starts a frame
//   cmos_href        camera line valid
//   cmos_data        camera byte bus
//   write_addr       frame-buffer address of the current write
//   pixel_data       RGB444 pixel of the current write
//   write_en         one-cycle write strobe
//   cmos_pixel_valid 1 for camera pixels, 0 for fill pixels
//   frame_done       one-cycle pulse at the end of a captured frame
//   overflow         sticky, too many pixels arrived in the current frame
module cmos_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [18:0] write_addr,
  output logic [11:0] pixel_data,
  output logic        write_en,
  output logic        cmos_pixel_valid,
  output logic        frame_done,
  output logic        overflow
);

  localparam logic [19:0] TOTAL_W = 20'(H_ACTIVE * V_ACTIVE);
  localparam logic [7:0]  SKIP_W  = 8'(SKIP_FRAMES);

`ifdef CMOS_BLANK_FILL_EN
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, FILL} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;
`endif

  state_t      state_q, state_d;
  logic        vsync_q;
  logic [7:0]  skip_q, skip_d;
  logic        phase_q, phase_d;
  logic [3:0]  red_q, red_d;
  // Writes issued in the current frame; one bit wider than the address so
  // that "buffer full" is representable while write_addr holds at the end.
  logic [19:0] cnt_q, cnt_d;
  logic [18:0] addr_q, addr_d;
  logic [11:0] pix_q, pix_d;
  logic        we_q, we_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic frame_start, frame_end;
  assign frame_start = vsync_q & ~cmos_vsync;
  assign frame_end   = ~vsync_q & cmos_vsync;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    phase_d = phase_q;
    red_d   = red_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    we_d    = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (capture_en) begin
          state_d = WAIT_FRAME;
          skip_d  = SKIP_W;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          if (skip_q != 8'd0) begin
            skip_d = skip_q - 8'd1;
          end else begin
            state_d = CAPTURE;
            cnt_d   = '0;
            addr_d  = '0;
            phase_d = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end
      CAPTURE: begin
        if (cmos_href) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            red_d = cmos_data[3:0];
          end else if (cnt_q < TOTAL_W) begin
            we_d    = 1'b1;
            valid_d = 1'b1;
            pix_d   = {red_q, cmos_data};
            addr_d  = cnt_q[18:0];
            cnt_d   = cnt_q + 20'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          // A dangling odd byte at the end of a line is dropped here.
          phase_d = 1'b0;
        end
        // The pixel finished on this same edge is still written above;
        // the fill decision uses the count including it.
        if (frame_end) begin
          skip_d = '0;
`ifdef CMOS_BLANK_FILL_EN
          if (cnt_d != TOTAL_W) begin
            state_d = FILL;
          end else begin
            done_d  = 1'b1;
            state_d = capture_en ? WAIT_FRAME : IDLE;
          end
`else
          done_d  = 1'b1;
          state_d = capture_en ? WAIT_FRAME : IDLE;
`endif
        end
      end
`ifdef CMOS_BLANK_FILL_EN
      FILL: begin
        if (cnt_q != TOTAL_W) begin
          we_d    = 1'b1;
          valid_d = 1'b0;
          pix_d   = '0;
          addr_d  = cnt_q[18:0];
          cnt_d   = cnt_q + 20'd1;
        end else begin
          done_d  = 1'b1;
          state_d = capture_en ? WAIT_FRAME : IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      skip_q  <= '0;
      phase_q <= 1'b0;
      red_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      pix_q   <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= cmos_vsync;
      skip_q  <= skip_d;
      phase_q <= phase_d;
      red_q   <= red_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign write_addr       = addr_q;
  assign pixel_data       = pix_q;
  assign write_en         = we_q;
  assign cmos_pixel_valid = valid_q;
  assign frame_done       = done_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_cmos_capture.sv
// tb/tb_cmos_capture.sv - self-checking bench for cmos_capture
module tb_cmos_capture;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int SKIP  = 2;
  localparam int TOTAL = H * V;
`ifdef CMOS_BLANK_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2;

  logic        clk = 1'b0;
  logic        rst, capture_en, cmos_vsync, cmos_href;
  logic [7:0]  cmos_data;
  logic [18:0] write_addr;
  logic [11:0] pixel_data;
  logic        write_en, cmos_pixel_valid, frame_done, overflow;

  always #5 clk = ~clk;

  cmos_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP)) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_data(cmos_data), .write_addr(write_addr),
    .pixel_data(pixel_data), .write_en(write_en),
    .cmos_pixel_valid(cmos_pixel_valid), .frame_done(frame_done),
    .overflow(overflow)
  );

  typedef struct { logic [18:0] addr; logic [11:0] data; logic valid; } wr_t;
  typedef struct { logic [7:0] b0; logic [7:0] b1; logic [11:0] pix; } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  vec_t vecs[8];
  int   n_vec = 0, n_bad = 0, done_seen = 0, done_exp = 0;

  int          m_state, m_skip, m_cnt;
  bit          m_phase;
  logic [3:0]  m_red;
  logic [18:0] m_last_addr;
  logic [11:0] m_last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, want no write", write_addr, pixel_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(write_addr), 32'(mon_e.addr));
        check("wr_data", 32'(pixel_data), 32'(mon_e.data));
        check("wr_valid", 32'(cmos_pixel_valid), 32'(mon_e.valid));
      end
    end
    if (frame_done === 1'b1) begin
      done_seen++;
      check("done_after_writes", exp_q.size(), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input logic [11:0] d, input logic v);
    wr_t e;
    e.addr = 19'(a); e.data = d; e.valid = v;
    exp_q.push_back(e);
    m_last_addr = 19'(a);
    m_last_data = d;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (m_state == M_CAP) begin
      if (!m_phase) m_red = b[3:0];
      else if (m_cnt < TOTAL) begin
        push(m_cnt, {m_red, b}, 1'b1);
        m_cnt++;
      end
      m_phase = !m_phase;
    end
  endtask

  task automatic m_end();
    if (m_state == M_CAP) begin
      if (FILL_EN) begin
        while (m_cnt < TOTAL) begin
          push(m_cnt, 12'h000, 1'b0);
          m_cnt++;
        end
      end
      done_exp++;
      m_skip  = 0;
      m_state = capture_en ? M_WAIT : M_IDLE;
    end
  endtask

  task automatic m_start();
    if (m_state == M_WAIT) begin
      if (m_skip > 0) m_skip--;
      else begin
        m_state = M_CAP; m_cnt = 0; m_phase = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cmos_href = 1'b1;
    cmos_data = b;
    step();
    m_byte(b);
  endtask

  task automatic href_low();
    cmos_href = 1'b0;
    cmos_data = 8'h00;
    step();
    m_phase = 0;
  endtask

  task automatic rand_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(8'($urandom_range(0, 255)));
    href_low();
  endtask

  task automatic vs_end();
    cmos_vsync = 1'b1;
    step();
    m_end();
  endtask

  task automatic vs_start();
    if (!cmos_vsync) vs_end();
    step();
    cmos_vsync = 1'b0;
    step();
    m_start();
    step();
  endtask

  task automatic frame(input int lines);
    vs_start();
    for (int l = 0; l < lines; l++) rand_line(2 * H);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || done_seen != done_exp) && k < 200) begin
      step();
      k++;
    end
    check({name, "_done_count"}, done_seen, done_exp);
    check({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic enable_from_idle();
    capture_en = 1'b1;
    step();
    if (m_state == M_IDLE) begin
      m_state = M_WAIT;
      m_skip  = SKIP;
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_addr"}, 32'(write_addr), 0);
    check({name, "_data"}, 32'(pixel_data), 0);
    check({name, "_we"}, 32'(write_en), 0);
    check({name, "_valid"}, 32'(cmos_pixel_valid), 0);
    check({name, "_done"}, 32'(frame_done), 0);
    check({name, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h0A, 8'hBC, 12'hABC};
    vecs[1] = '{8'hF5, 8'h00, 12'h500};
    vecs[2] = '{8'h33, 8'hFF, 12'h3FF};
    vecs[3] = '{8'h00, 8'h00, 12'h000};
    vecs[4] = '{8'hFF, 8'hFF, 12'hFFF};
    vecs[5] = '{8'h1C, 8'h5A, 12'hC5A};
    vecs[6] = '{8'h2E, 8'h81, 12'hE81};
    vecs[7] = '{8'h07, 8'h7E, 12'h77E};

    rst = 1'b1; capture_en = 1'b0; cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_data = 8'h00;
    m_state = M_IDLE; m_skip = 0; m_cnt = 0; m_phase = 0; m_red = 0;
    m_last_addr = 0; m_last_data = 0;
    step(); step();
    check_zero("reset");
    rst = 1'b0;
    enable_from_idle();

    // two skipped frames, then a captured frame led by the table line
    frame(V);
    frame(V);
    vs_start();
    check("start_addr", 32'(write_addr), 0);
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].b0);
      check("phase0_no_write", 32'(write_en), 0);
      send_byte(vecs[i].b1);
      check("pix_we", 32'(write_en), 1);
      check("pix_valid", 32'(cmos_pixel_valid), 1);
      check("pix_data", 32'(pixel_data), 32'(vecs[i].pix));
      check("pix_addr", 32'(write_addr), i);
    end
    href_low();
    check("we_low_after_line", 32'(write_en), 0);
    for (int l = 1; l < V; l++) rand_line(2 * H);
    vs_end();
    drain("frame3");
    check("frame3_addr_hold", 32'(write_addr), TOTAL - 1);
    check("frame3_no_ovf", 32'(overflow), 0);

    frame(V);
    vs_end();
    drain("frame4");
    check("two_frames_done", done_seen, 2);

    // odd byte count line: last byte dropped, next line restarts at phase 0
    vs_start();
    rand_line(2 * H + 1);
    check("odd_line_last_addr", 32'(write_addr), H - 1);
    send_byte(8'h05);
    send_byte(8'h67);
    check("next_line_addr", 32'(write_addr), H);
    check("next_line_data", 32'(pixel_data), 12'h567);
    for (int i = 2; i < 2 * H; i++) send_byte(8'($urandom_range(0, 255)));
    href_low();
    rand_line(2 * H);
    rand_line(2 * H);
    vs_end();
    drain("odd_frame");

    // two extra pixels: dropped, overflow sticky until next captured start
    frame(V);
    rand_line(4);
    check("overflow_set", 32'(overflow), 1);
    check("overflow_addr_hold", 32'(write_addr), TOTAL - 1);
    vs_end();
    drain("ovf_frame");
    check("overflow_sticky", 32'(overflow), 1);
    vs_start();
    check("overflow_cleared", 32'(overflow), 0);

    // short frame, last pixel completes on the vsync rising edge
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)));
    cmos_vsync = 1'b1;
    send_byte(8'hD4);
    m_end();
    check("same_cycle_we", 32'(write_en), 1);
    check("same_cycle_addr", 32'(write_addr), 4);
    href_low();
    drain("short_frame");
    check("short_last_addr", 32'(write_addr), 32'(m_last_addr));
    check("short_last_data", 32'(pixel_data), 32'(m_last_data));

    // capture_en dropped mid-frame: frame completes, then idle
    frame(2);
    capture_en = 1'b0;
    rand_line(2 * H);
    rand_line(2 * H);
    vs_end();
    drain("en_drop_frame");
    frame(V);
    vs_end();
    drain("idle_frame");

    // re-enable, reach mid-capture, then reset
    enable_from_idle();
    frame(V);
    frame(V);
    frame(2);
    check("pre_reset_addr", 32'(write_addr), 2 * H - 1);
    rst = 1'b1;
    step();
    check_zero("mid_reset");
    check("mid_reset_pending", exp_q.size(), 0);
    m_state = M_IDLE;
    rst = 1'b0;
    enable_from_idle();
    frame(V);
    frame(V);
    frame(V);
    vs_end();
    drain("post_reset_frame");
    check("post_reset_addr", 32'(write_addr), TOTAL - 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cmos_capture.md
CMOS_CAPTURE -- requirements
Module: cmos_capture

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, pixels per active line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, active lines per frame; H_ACTIVE*V_ACTIVE SHALL be at most 2^19.
REQ-003 The block SHALL have parameter SKIP_FRAMES, default 2, the number of whole frames discarded after capture is enabled.
REQ-004 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  camera pixel clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- capture_en  input  1  enables frame capture.
- cmos_vsync  input  1  camera vertical sync, active high.
- cmos_href  input  1  camera line valid.
- cmos_data  input  8  camera byte bus.
- write_addr  output  19  frame-buffer pixel address.
- pixel_data  output  12  RGB444 pixel.
- write_en  output  1  one-cycle frame-buffer write strobe.
- cmos_pixel_valid  output  1  high when pixel_data is camera data, low for fill data.
- frame_done  output  1  one-cycle pulse at end of a captured frame.
- overflow  output  1  sticky; more than H_ACTIVE*V_ACTIVE pixels arrived in the current frame.

Function
REQ-005 State machine SHALL have states IDLE, WAIT_FRAME, CAPTURE, plus FILL when CMOS_BLANK_FILL_EN is defined.
REQ-006 Frame start SHALL be the falling edge of cmos_vsync: the registered previous value is 1 and the current value is 0.
REQ-007 IDLE SHALL go to WAIT_FRAME when capture_en=1, loading the skip counter with SKIP_FRAMES.
REQ-008 In WAIT_FRAME, each frame start SHALL decrement a nonzero skip counter; a frame start with the counter at 0 SHALL enter CAPTURE with write_addr=0, byte phase=0 and overflow cleared.
REQ-009 In CAPTURE, each cycle with cmos_href=1 SHALL toggle the byte phase: phase 0 latches cmos_data[3:0] as R; phase 1 forms the pixel {R, cmos_data[7:0]}.
REQ-010 A pixel formed at clock edge N SHALL produce write_en=1, cmos_pixel_valid=1, pixel_data and write_addr at edge N+1, for exactly one cycle.
REQ-011 write_addr SHALL increment by 1 after each write and SHALL hold at H_ACTIVE*V_ACTIVE-1 after the last write.
REQ-012 Pixels formed after H_ACTIVE*V_ACTIVE writes SHALL be dropped (no write_en) and SHALL set overflow.
REQ-013 cmos_href=0 SHALL reset the byte phase to 0; a dangling odd byte SHALL be discarded.
REQ-014 A rising edge of cmos_vsync in CAPTURE SHALL end the frame.
REQ-015 Frame end in a complete frame (or without the macro) SHALL pulse frame_done one cycle and go to WAIT_FRAME if capture_en=1, otherwise to IDLE; the skip counter SHALL stay 0.
REQ-016 capture_en changes SHALL take effect only in IDLE and at frame end; deassertion mid-frame SHALL NOT truncate the frame.
REQ-017 Outside a write cycle, write_en and cmos_pixel_valid SHALL be 0, and pixel_data and write_addr SHALL hold their last values.
REQ-018 A pixel completed in the same cycle as the vsync rising edge SHALL still be written.

Reset
REQ-019 rst=1 SHALL force state IDLE, write_addr=0, pixel_data=0, write_en=0, cmos_pixel_valid=0, frame_done=0, overflow=0, byte phase=0, skip counter=0 and the vsync history register=0, at the next edge.
REQ-020 rst mid-frame SHALL abandon the frame; after reset, capture SHALL restart with SKIP_FRAMES skipped frames.

Configuration
REQ-021 With CMOS_BLANK_FILL_EN defined, frame end with fewer than H_ACTIVE*V_ACTIVE writes SHALL enter FILL.
REQ-022 FILL SHALL write every remaining address, one per cycle, with write_en=1, cmos_pixel_valid=0 and pixel_data=0.
REQ-023 FILL SHALL pulse frame_done after its last write and SHALL ignore cmos_vsync, cmos_href and cmos_data.
REQ-024 Without CMOS_BLANK_FILL_EN, the FILL state and its logic SHALL be absent and short frames SHALL end immediately.

Verification
REQ-025 rst, capture_en=1, SKIP_FRAMES=2, 4 full 640x480 frames -> frames 1-2 produce no write_en; frames 3-4 each produce 307200 writes, addr 0..307199, and one frame_done.
REQ-026 Bytes 0x0A,0xBC on consecutive href cycles -> next cycle write_en=1, pixel_data=0xABC, cmos_pixel_valid=1.
REQ-027 Line with 1281 bytes then href low -> 640 writes; next line starts at phase 0 with addr 640.
REQ-028 Frame with 307202 pixels -> writes stop at addr 307199 and overflow=1 until next captured frame start.
REQ-029 Frame ending after 100 pixels, macro defined -> 307100 fill writes (addr 100..307199, valid=0, data 0), then frame_done; without macro -> frame_done immediately, no fill.
REQ-030 rst asserted at addr 5000 mid-capture -> all outputs 0 next cycle, no write_en until SKIP_FRAMES frames have passed.
